// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: FSM encoding,
// well-known scan-code constants and the odd-parity helper.
package ps2_pkg;

    // Frame receiver states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // Prefix bytes handled downstream by the key-decode stage
    localparam logic [7:0] SCAN_BREAK = 8'hF0;
    localparam logic [7:0] SCAN_EXT   = 8'hE0;

    // Key codes of interest to the consumer
    localparam logic [7:0] KEY_R = 8'h2D;
    localparam logic [7:0] KEY_W = 8'h1D;
    localparam logic [7:0] KEY_S = 8'h1B;

    // PS/2 uses odd parity: data plus parity bit holds an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Scan-code buffer. Pointers carry one extra wrap bit so full/empty fall
// out of an MSB compare. scan_ready is registered and dropped for one
// cycle after every pop so the consumer's oneshot always sees a new edge.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop_req,
    output logic       scan_ready,
    output logic [7:0] scan_code,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][7:0] mem;
    logic [AW:0]           wr_ptr, rd_ptr;
    logic [AW:0]           wr_nxt, rd_nxt;
    logic                  full, empty_nxt, pop, do_push;

    // Pointer arithmetic and accept/drop decisions
    always_comb begin
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = pop_req & scan_ready;
        // a same-cycle pop frees the slot the push needs
        do_push   = push & (~full | pop);
        wr_nxt    = wr_ptr + (AW+1)'(do_push);
        rd_nxt    = rd_ptr + (AW+1)'(pop);
        empty_nxt = (wr_nxt == rd_nxt);
    end

    assign scan_code = mem[rd_ptr[AW-1:0]];

    // Storage, pointers, ready-gap and overflow pulse
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            scan_ready <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (do_push)
                mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            scan_ready <= pop ? 1'b0 : ~empty_nxt;
            overflow   <= push & full & ~pop;
        end
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard frame receiver: synchronises PS2_CLK/PS2_DAT, deserialises
// 11-bit frames into scan codes and buffers them in ps2_byte_fifo.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       read,
    output logic       scan_ready,
    output logic [7:0] scan_code,
    output logic       frame_err,
    output logic       overflow
);

    localparam int             TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev, fall, dat;
    ps2_state_t    state, state_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shift, shift_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          push_q, push_nxt, err_nxt, stop_ok;

    // Two-flop synchronisers; lines idle high so reset to 1
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];
    assign dat  = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    logic par_q;

    // Parity bit is kept only when it is going to be checked
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            par_q <= 1'b0;
        else if (fall && state == ST_PARITY)
            par_q <= dat;
    end

    assign stop_ok = dat & odd_parity_ok(shift, par_q);
`else
    assign stop_ok = dat;
`endif

    // Frame FSM state and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            tmo_cnt   <= '0;
            push_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_nxt;
            shift     <= shift_nxt;
            tmo_cnt   <= tmo_nxt;
            push_q    <= push_nxt;
            frame_err <= err_nxt;
        end
    end

    // Next-state: advance one bit per falling edge, abort on a stall
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        tmo_nxt   = '0;
        push_nxt  = 1'b0;
        err_nxt   = 1'b0;

        if (state != ST_IDLE && !fall) begin
            if (tmo_cnt == TMO_LAST) begin
                state_nxt = ST_IDLE;
                err_nxt   = 1'b1;
            end else begin
                tmo_nxt = tmo_cnt + 1'b1;
            end
        end

        if (fall) begin
            unique case (state)
                ST_IDLE: begin
                    // a high start bit is line noise, not an error
                    if (!dat) begin
                        state_nxt = ST_DATA;
                        bit_nxt   = '0;
                    end
                end
                ST_DATA: begin
                    shift_nxt = {dat, shift[7:1]};
                    bit_nxt   = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = ST_PARITY;
                end
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP: begin
                    state_nxt = ST_IDLE;
                    push_nxt  = stop_ok;
                    err_nxt   = ~stop_ok;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // shift is stable for the cycle after the stop edge, so it feeds the push directly
    ps2_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock      (clock),
        .resetn     (resetn),
        .push       (push_q),
        .push_data  (shift),
        .pop_req    (read),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: table of single frames plus
// hand-written sequences for the FIFO, ready-gap, timeout and reset cases.
module tb_ps2_scan_receiver;

    localparam int DEPTH = 4;
    localparam int TMO   = 1000;
    localparam int HALF  = 20;

`ifdef PS2_PARITY_CHECK_EN
    localparam logic PAR_CHK = 1'b1;
`else
    localparam logic PAR_CHK = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic       read = 1'b0;
    logic       scan_ready;
    logic [7:0] scan_code;
    logic       frame_err;
    logic       overflow;

    ps2_scan_receiver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .read       (read),
        .scan_ready (scan_ready),
        .scan_code  (scan_code),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #10 clock = ~clock;

    int cyc = 0, err_cnt = 0, ovf_cnt = 0, last_err_cyc = 0, last_fall_cyc = 0;
    int n_chk = 0, n_fail = 0;

    // Pulse monitor, sampled away from the active edge
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (frame_err) begin
            err_cnt = err_cnt + 1;
            last_err_cyc = cyc;
        end
        if (overflow) ovf_cnt = ovf_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_ok;
        logic       exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // bits[0] goes out first; data changes while the PS/2 clock is high
    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = b[i];
            tick(HALF);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bits({s, p, d, 1'b0}, 11);
        tick(HALF);
    endtask

    task automatic pop();
        read = 1'b1;
        tick(1);
        read = 1'b0;
    endtask

    initial begin
        int e0, o0, waited;
        logic [7:0] exp_seq [4];

        // hand-computed odd parity: 2D/1B/1D/00/FF -> 1, E0/07 -> 0
        tbl[0] = '{8'h2D, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{8'h1B, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{8'h1D, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{8'hE0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{8'h2D, 1'b0, 1'b1, ~PAR_CHK, PAR_CHK};
        tbl[7] = '{8'h07, 1'b0, 1'b1, 1'b1, 1'b0};

        tick(3);
        chk("reset_ready", scan_ready, 0);
        chk("reset_code", scan_code, 0);
        chk("reset_err", frame_err, 0);
        chk("reset_ovf", overflow, 0);
        resetn = 1'b1;
        tick(5);

        // Single-frame table
        for (int i = 0; i < 8; i++) begin
            e0 = err_cnt;
            o0 = ovf_cnt;
            send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
            chk($sformatf("tbl%0d_ready", i), scan_ready, tbl[i].exp_ok);
            if (tbl[i].exp_ok) chk($sformatf("tbl%0d_code", i), scan_code, tbl[i].data);
            chk($sformatf("tbl%0d_err", i), err_cnt - e0, tbl[i].exp_err);
            chk($sformatf("tbl%0d_ovf", i), ovf_cnt - o0, 0);
            if (tbl[i].exp_ok) begin
                pop();
                chk($sformatf("tbl%0d_pop_low", i), scan_ready, 0);
                tick(2);
                chk($sformatf("tbl%0d_empty", i), scan_ready, 0);
            end
        end

        // Lone edge with data high in IDLE, plus a read while empty: both ignored
        e0 = err_cnt;
        send_bits(11'h001, 1);
        tick(HALF);
        pop();
        tick(2);
        chk("idle_hi_ready", scan_ready, 0);
        chk("idle_hi_err", err_cnt - e0, 0);
        send_frame(8'h1D, 1'b1, 1'b1);
        chk("after_idle_ready", scan_ready, 1);
        chk("after_idle_code", scan_code, 8'h1D);
        pop();
        tick(2);

        // Two frames, ready gap between them
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1D, 1'b1, 1'b1);
        chk("two_head_ready", scan_ready, 1);
        chk("two_head_code", scan_code, 8'hF0);
        pop();
        chk("two_gap", scan_ready, 0);
        tick(1);
        chk("two_second_ready", scan_ready, 1);
        chk("two_second_code", scan_code, 8'h1D);
        pop();
        chk("two_drop", scan_ready, 0);
        tick(2);
        chk("two_empty", scan_ready, 0);

        // Timeout mid-frame: start + 3 data bits, then stall
        e0 = err_cnt;
        send_bits(11'b000_0000_1010, 4);
        waited = 0;
        while (err_cnt == e0 && waited < TMO + 200) begin
            tick(1);
            waited++;
        end
        chk("tmo_fired", err_cnt - e0, 1);
        chk("tmo_window", ((last_err_cyc - last_fall_cyc) >= TMO - 2) &&
                          ((last_err_cyc - last_fall_cyc) <= TMO + 12), 1);
        tick(50);
        chk("tmo_single", err_cnt - e0, 1);
        chk("tmo_no_byte", scan_ready, 0);
        send_frame(8'h1D, 1'b1, 1'b1);
        chk("tmo_next_ready", scan_ready, 1);
        chk("tmo_next_code", scan_code, 8'h1D);
        pop();
        tick(2);

        // Overflow: five frames into a four-entry buffer
        o0 = ovf_cnt;
        send_frame(8'h01, 1'b0, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1);
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h04, 1'b0, 1'b1);
        send_frame(8'h05, 1'b1, 1'b1);
        chk("ovf_pulses", ovf_cnt - o0, 1);
        exp_seq[0] = 8'h01; exp_seq[1] = 8'h02; exp_seq[2] = 8'h03; exp_seq[3] = 8'h04;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ovf_ready%0d", k), scan_ready, 1);
            chk($sformatf("ovf_code%0d", k), scan_code, exp_seq[k]);
            pop();
            chk($sformatf("ovf_gap%0d", k), scan_ready, 0);
            // a read during the gap must not pop
            if (k == 0) pop();
            else tick(1);
        end
        tick(2);
        chk("ovf_drained", scan_ready, 0);

        // Reset mid-frame with a byte buffered: flush, no error pulse
        send_frame(8'h2D, 1'b1, 1'b1);
        chk("rst_pre_ready", scan_ready, 1);
        e0 = err_cnt;
        send_bits(11'b000_0101_1010, 5);
        resetn = 1'b0;
        tick(2);
        chk("rst_ready", scan_ready, 0);
        chk("rst_code", scan_code, 0);
        chk("rst_err", err_cnt - e0, 0);
        resetn = 1'b1;
        tick(5);
        send_frame(8'h1B, 1'b1, 1'b1);
        chk("rst_next_ready", scan_ready, 1);
        chk("rst_next_code", scan_code, 8'h1B);
        chk("rst_next_err", err_cnt - e0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
